// File: rtl/unified_mem_responder_pkg.sv
// Shared types for unified_mem_responder: FSM state and port-id enums.
// Stall-injection LFSR helpers exist only with MEM_STALL_INJECT_EN.
package memrs;
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;
endpackage

package memport;
  typedef enum logic {
    IMEM,
    DMEM
  } port_t;
endpackage

package unified_mem_responder_pkg;
  localparam int CNT_W = 4;
`ifdef MEM_STALL_INJECT_EN
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Fibonacci LFSR, taps 8,6,5,4
  function automatic logic [7:0] lfsr_next(
    input logic [7:0] s
  );
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
`endif
endpackage

// File: rtl/unified_mem_responder_mem_array.sv
// mem_array: single-port synchronous RAM, byte write enables, registered read.
// Ports: clk, i_en/i_we/i_be/i_addr/i_wdata request, o_rdata read register.
module mem_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [2**AW];
  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_q <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/unified_mem_responder.sv
// unified_mem_responder: one RAM shared by fetch (pc/imem_*) and data
// (mem_*) ports, round-robin arbitration, fixed LATENCY grant-to-resp.
// Ports: clk, rst (async, active-low), fetch pc/imem_read -> instr/imem_resp,
// data mem_address/wdata/read/write/byte_enable -> mem_rdata/mem_resp.
// MEM_STALL_INJECT_EN adds 0-3 LFSR-chosen WAIT cycles per transaction.
module unified_mem_responder
  import unified_mem_responder_pkg::*;
#(
  parameter int WORDS_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        imem_read,
  output logic [31:0] instr,
  output logic        imem_resp,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp
);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

  memrs::state_t      r_state;
  memport::port_t     r_port;
  memport::port_t     r_last;
  logic               r_wr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_imem_resp;
  logic               r_mem_resp;
  logic [31:0]        r_instr;
  logic [31:0]        r_rdata;

  logic               w_dreq;
  logic               w_ireq;
  logic               w_grant;
  memport::port_t     w_pick;
  logic               w_we;
  logic [WORDS_LOG2-1:0] w_addr;
  logic [CNT_W-1:0]   w_extra;
  logic [CNT_W-1:0]   w_total;
  logic [31:0]        w_q;
  logic               w_unused;

  assign w_dreq  = mem_read | mem_write;
  assign w_ireq  = imem_read;
  assign w_grant = (r_state == memrs::IDLE)
                 & (w_dreq | w_ireq);

  // dmem wins a tie unless it took the previous grant
  assign w_pick = (w_dreq & (~w_ireq
                 | (r_last != memport::DMEM)))
                ? memport::DMEM : memport::IMEM;

  assign w_we   = (w_pick == memport::DMEM) & mem_write;
  assign w_addr = (w_pick == memport::DMEM)
                ? mem_address[WORDS_LOG2+1:2]
                : pc[WORDS_LOG2+1:2];

`ifdef MEM_STALL_INJECT_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_grant) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_extra = {{(CNT_W-2){1'b0}}, r_lfsr[1:0]};
`else
  assign w_extra = '0;
`endif

  assign w_total = LAT + w_extra;

  mem_array #(
    .AW (WORDS_LOG2)
  ) u_mem_array (
    .clk     (clk),
    .i_en    (w_grant),
    .i_we    (w_we),
    .i_be    (mem_byte_enable),
    .i_addr  (w_addr),
    .i_wdata (mem_wdata),
    .o_rdata (w_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= memrs::IDLE;
      r_port      <= memport::IMEM;
      r_last      <= memport::IMEM;
      r_wr        <= 1'b0;
      r_cnt       <= '0;
      r_imem_resp <= 1'b0;
      r_mem_resp  <= 1'b0;
      r_instr     <= '0;
      r_rdata     <= '0;
    end else begin
      r_imem_resp <= 1'b0;
      r_mem_resp  <= 1'b0;
      case (r_state)
        memrs::IDLE: begin
          if (w_grant) begin
            r_port <= w_pick;
            r_last <= w_pick;
            r_wr   <= w_we;
            if (w_total == CNT_W'(1)) begin
              r_state     <= memrs::RESP;
              r_imem_resp <= (w_pick == memport::IMEM);
              r_mem_resp  <= (w_pick == memport::DMEM);
            end else begin
              r_state <= memrs::WAIT;
              r_cnt   <= w_total - CNT_W'(2);
            end
          end
        end
        memrs::WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= memrs::RESP;
            r_imem_resp <= (r_port == memport::IMEM);
            r_mem_resp  <= (r_port == memport::DMEM);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        memrs::RESP: begin
          r_state <= memrs::IDLE;
          // RAM output is stable through RESP; latch it for holding
          if (r_port == memport::IMEM) begin
            r_instr <= w_q;
          end else if (!r_wr) begin
            r_rdata <= w_q;
          end
        end
        default: begin
          r_state <= memrs::IDLE;
        end
      endcase
    end
  end

  // during the resp cycle present the RAM read register directly
  assign imem_resp = r_imem_resp;
  assign mem_resp  = r_mem_resp;
  assign instr     = r_imem_resp ? w_q : r_instr;
  assign mem_rdata = (r_mem_resp && !r_wr) ? w_q : r_rdata;

  assign w_unused = ^{pc[31:WORDS_LOG2+2], pc[1:0],
                      mem_address[31:WORDS_LOG2+2],
                      mem_address[1:0]};
endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed self-checking bench for unified_mem_responder.
// Stall-range scenario runs only with MEM_STALL_INJECT_EN.
module tb_unified_mem_responder;
  localparam int WL  = 10;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        imem_read = 1'b0;
  logic [31:0] instr;
  logic        imem_resp;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_byte_enable = '0;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  unified_mem_responder #(
    .WORDS_LOG2 (WL),
    .LATENCY    (LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .imem_read       (imem_read),
    .instr           (instr),
    .imem_resp       (imem_resp),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h",
                tag, obs, exp);
  endtask

  // issue in IDLE, withdraw after grant edge, wait for resp
  task automatic dop(input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic rd, input logic wr,
                     input logic [3:0] be,
                     output int lat,
                     output logic [31:0] rdv);
    logic got;
    got = 1'b0;
    lat = 0;
    mem_address = a;
    mem_wdata = wd;
    mem_read = rd;
    mem_write = wr;
    mem_byte_enable = be;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      lat++;
      mem_read = 1'b0;
      mem_write = 1'b0;
      if (mem_resp) got = 1'b1;
    end
    rdv = mem_rdata;
    chk("dmem_resp_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    chk("dmem_pulse", 32'(mem_resp), 32'd0);
  endtask

  task automatic iop(input logic [31:0] a,
                     output int lat,
                     output logic [31:0] iv);
    logic got;
    got = 1'b0;
    lat = 0;
    pc = a;
    imem_read = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      lat++;
      imem_read = 1'b0;
      if (imem_resp) got = 1'b1;
    end
    iv = instr;
    chk("imem_resp_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    chk("imem_pulse", 32'(imem_resp), 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] v;
    logic quiet;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr", instr, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_resp", {30'b0, imem_resp, mem_resp}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    dop(32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF, lat, v);
    chk("wr_lat", lat, 32'd2);
    dop(32'h100, 32'h0, 1'b1, 1'b0, 4'hF, lat, v);
    chk("rd_lat", lat, 32'd2);
    chk("rd_data", v, 32'hDEADBEEF);
    chk("rd_hold", mem_rdata, 32'hDEADBEEF);

    dop(32'h100, 32'h000000AA, 1'b0, 1'b1, 4'b0001, lat, v);
    chk("be_wr_keeps_rdata", v, 32'hDEADBEEF);
    dop(32'h100, 32'h0, 1'b1, 1'b0, 4'hF, lat, v);
    chk("be_rd", v, 32'hDEADBEAA);

    dop(32'h100, 32'hFFFFFFFF, 1'b0, 1'b1, 4'b0000, lat, v);
    chk("be0_lat", lat, 32'd2);
    dop(32'h100, 32'h0, 1'b1, 1'b0, 4'hF, lat, v);
    chk("be0_unchanged", v, 32'hDEADBEAA);

    dop(32'h100, 32'h11223344, 1'b1, 1'b1, 4'hF, lat, v);
    chk("rdwr_rdata_held", v, 32'hDEADBEAA);
    dop(32'h100, 32'h0, 1'b1, 1'b0, 4'hF, lat, v);
    chk("rdwr_wrote", v, 32'h11223344);

    dop(32'h104, 32'h12345678, 1'b0, 1'b1, 4'hF, lat, v);
    iop(32'h104, lat, v);
    chk("fetch_lat", lat, 32'd2);
    chk("fetch", v, 32'h12345678);
    iop(32'h104 + (32'd4 << WL), lat, v);
    chk("fetch_alias", v, 32'h12345678);
    chk("instr_hold", instr, 32'h12345678);
    dop(32'h105, 32'h0, 1'b1, 1'b0, 4'hF, lat, v);
    chk("low_bits_ignored", v, 32'h12345678);

    // reset during WAIT of a read
    mem_address = 32'h100;
    mem_read = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("mid_rst_rdata", mem_rdata, 32'h0);
    quiet = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (mem_resp || imem_resp) quiet = 1'b0;
    end
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_resp || imem_resp) quiet = 1'b0;
    end
    chk("mid_rst_no_resp", 32'(quiet), 32'd1);
    dop(32'h100, 32'h0, 1'b1, 1'b0, 4'hF, lat, v);
    chk("post_rst_lat", lat, 32'd2);
    chk("post_rst_data", v, 32'h11223344);

    // both ports held from reset: D, I, D, I
    rst = 1'b0;
    pc = 32'h104;
    mem_address = 32'h100;
    imem_read = 1'b1;
    mem_read = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      @(posedge clk); #1;
      chk($sformatf("rr_d_s%0d", s), 32'(mem_resp),
          32'((s == 2) || (s == 8)));
      chk($sformatf("rr_i_s%0d", s), 32'(imem_resp),
          32'((s == 5) || (s == 11)));
      if (s == 2) chk("rr_d_data", mem_rdata, 32'h11223344);
      if (s == 5) chk("rr_i_data", instr, 32'h12345678);
      if (s == 12) begin
        imem_read = 1'b0;
        mem_read = 1'b0;
      end
    end
    repeat (4) @(posedge clk);
    #1;

`ifdef MEM_STALL_INJECT_EN
    for (int i = 0; i < 8; i++) begin
      dop(32'h200 + 32'(i * 4), 32'hA5000000 ^ 32'(i * 3),
          1'b0, 1'b1, 4'hF, lat, v);
    end
    for (int i = 0; i < 100; i++) begin
      dop(32'h200 + 32'((i % 8) * 4), 32'h0,
          1'b1, 1'b0, 4'hF, lat, v);
      chk("stall_gap", 32'((lat >= 2) && (lat <= 5)), 32'd1);
      chk("stall_data", v, 32'hA5000000 ^ 32'((i % 8) * 3));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/unified_mem_responder.md
UNIFIED_MEM_RESPONDER -- requirements
Module: unified_mem_responder

Interface
REQ-001 SHALL have parameter WORDS_LOG2, default 10, giving backing array depth as 2**WORDS_LOG2 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, legal range 1..8, giving cycles from grant to resp.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port pc, input, 32 bits: instruction fetch address.
REQ-006 SHALL have port imem_read, input, 1 bit: fetch request, held until imem_resp.
REQ-007 SHALL have port instr, output, 32 bits: fetch data, valid when imem_resp is high.
REQ-008 SHALL have port imem_resp, output, 1 bit: fetch done, one-cycle pulse.
REQ-009 SHALL have ports mem_address (input, 32), mem_wdata (input, 32), mem_read (input, 1), mem_write (input, 1) and mem_byte_enable (input, 4): the data request.
REQ-010 SHALL have port mem_rdata, output, 32 bits: load data, valid when mem_resp is high.
REQ-011 SHALL have port mem_resp, output, 1 bit: data access done, one-cycle pulse.

Function
REQ-012 SHALL serve both ports from one single-port array, one transaction in flight at a time.
REQ-013 SHALL index the array with address bits [WORDS_LOG2+1:2]; higher bits alias and bits [1:0] are ignored.
REQ-014 SHALL use FSM states IDLE, WAIT and RESP: IDLE goes to WAIT on grant (or to RESP if LATENCY==1), WAIT goes to RESP when the countdown reaches 0, RESP returns to IDLE.
REQ-015 SHALL drive the resp for the granted port high for exactly 1 cycle, LATENCY cycles after the grant cycle, in state RESP.
REQ-016 SHALL perform the array access in the grant cycle and hold the result in registered rdata/instr until that port's next resp.
REQ-017 SHALL write only the bytes whose mem_byte_enable bit is set; mbe 4'b0000 still completes with mem_resp and leaves the array unchanged.
REQ-018 SHALL give mem_write precedence when mem_read and mem_write are both high; mem_rdata is then unchanged.
REQ-019 SHALL arbitrate in IDLE as follows: with only one port requesting, that port wins; with both requesting, dmem wins unless the last grant was dmem, in which case imem wins (round-robin).
REQ-020 SHALL NOT grant in the RESP cycle; a request still asserted after its resp is a new request, eligible in the following IDLE cycle.
REQ-021 SHALL complete a granted transaction even if the request is withdrawn before resp.

Reset
REQ-022 SHALL, while rst is low, force the FSM to IDLE, imem_resp and mem_resp to 0, instr and mem_rdata to 0, the countdown to 0, and last-grant to imem.
REQ-023 SHALL drop any in-flight transaction on reset with no resp issued; a write already performed in its grant cycle remains.
REQ-024 SHALL NOT reset array contents.

Configuration
REQ-025 SHALL, when MEM_STALL_INJECT_EN is defined, add 0-3 extra WAIT cycles per transaction taken from lfsr[1:0], using an 8-bit LFSR (taps 8,6,5,4) seeded 8'hA5 at reset and advanced once per grant.
REQ-026 SHALL, when MEM_STALL_INJECT_EN is undefined, have exactly LATENCY cycles from grant to resp and contain no LFSR logic.

Structure
REQ-027 SHALL place the state enum (memrs::state_t) and the port-id enum (memport::port_t) in the shared types package.
REQ-028 SHALL implement the array as sub-module mem_array: a single-port synchronous RAM with a 4-bit byte write enable and a registered read.

Verification
REQ-029 Bench SHALL cover: write 0xDEADBEEF to 0x100 with mbe 1111, then read 0x100 -> mem_resp exactly 2 cycles after each grant; mem_rdata == 0xDEADBEEF.
REQ-030 Bench SHALL cover: write 0x000000AA to 0x100 with mbe 0001 over 0xDEADBEEF, then read -> 0xDEADBEAA.
REQ-031 Bench SHALL cover: imem_read and mem_read held continuously from reset -> grants dmem, imem, dmem, imem; each resp is a single-cycle pulse.
REQ-032 Bench SHALL cover: rst low in the WAIT state of a read -> no resp; the re-issued read after release completes normally.
REQ-033 Bench SHALL cover: write 0x12345678 to 0x104, then fetch pc=0x104 and pc=0x104+(4<<WORDS_LOG2) -> instr == 0x12345678 for both (aliasing).
REQ-034 Bench SHALL cover: with MEM_STALL_INJECT_EN defined, 100 reads -> every grant-to-resp gap is within 2..5 cycles and data is correct.
